risc_multicycle_core: RTL and testbench

Parametrised multi-cycle RV32I-subset core with a shared instruction/data memory port and a ready/request handshake. It executes each instruction over 3–5 states instead of one cycle. It replaces the single-cycle processor top as the CPU block in the SoC and tolerates wait-stated memory. It adds instructions the single-cycle datapath lacks: branches, jumps and set-less-than. It also adds a defined halt on illegal or misaligned operations.

---
 rtl/rvmc_pkg.sv | 40 ++++
 rtl/rvmc_regfile.sv | 33 +++
 rtl/risc_multicycle_core.sv | 194 +++++++++++++++++++
 tb/tb_risc_multicycle_core.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvmc_pkg.sv
// Shared encodings and enums for the multi-cycle RV32I-subset core.
package rvmc_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE    = 7'h00;
  localparam logic [6:0] F7_SUB     = 7'h20;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEMORY,
    WRITEBACK,
    HALT
  } state_t;

endpackage

// File: rtl/rvmc_regfile.sv
// Register file: two async read ports, one sync write port, x0 reads zero.
module rvmc_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rd_data
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (we && rd_addr != '0) regs[rd_addr] <= rd_data;
  end

  // Write-first bypass; x0 is never stored so its read is forced to zero.
  always_comb begin
    rs1_data = regs[rs1_addr];
    rs2_data = regs[rs2_addr];
    if (we && rd_addr == rs1_addr) rs1_data = rd_data;
    if (we && rd_addr == rs2_addr) rs2_data = rd_data;
    if (rs1_addr == '0) rs1_data = '0;
    if (rs2_addr == '0) rs2_data = '0;
  end

endmodule

// File: rtl/risc_multicycle_core.sv
// Multi-cycle RV32I-subset core sharing one memory port for fetch and data.
module risc_multicycle_core
  import rvmc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              NREGS    = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            retire,
  output logic            halt
);

  localparam int AW = $clog2(NREGS);

  state_t          state, state_nx;
  logic [XLEN-1:0] pc, ir, a, b, imm, alu_out, mdr;
  logic [XLEN-1:0] imm_dec, alu_b, alu_res, pc_plus4, br_target;
  logic [XLEN-1:0] rs1_data, rs2_data, rf_wdata;
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic            legal, taken, exec_fault, rf_we, is_store;
  alu_op_t         alu_op;

  assign opcode   = ir[6:0];
  assign funct3   = ir[14:12];
  assign funct7   = ir[31:25];
  assign is_store = (opcode == OPC_STORE);

  always_comb begin
    case (opcode)
      OPC_STORE:  imm_dec = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
      OPC_BRANCH: imm_dec = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OPC_JAL:    imm_dec = {{(XLEN-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:    imm_dec = {{(XLEN-12){ir[31]}}, ir[31:20]};
    endcase
  end

  always_comb begin
    case (opcode)
      OPC_OP:     legal = (funct7 == F7_BASE && funct3 inside {F3_ADD_SUB, F3_SLT, F3_OR, F3_AND})
                       || (funct7 == F7_SUB && funct3 == F3_ADD_SUB);
      OPC_OP_IMM: legal = (funct3 == F3_ADD_SUB);
      OPC_LOAD:   legal = (funct3 == F3_LW);
      OPC_STORE:  legal = (funct3 == F3_SW);
      OPC_BRANCH: legal = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
      OPC_JAL:    legal = 1'b1;
      default:    legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_op = ALU_ADD;
    if (opcode == OPC_OP) begin
      case (funct3)
        F3_ADD_SUB: alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
        F3_SLT:     alu_op = ALU_SLT;
        F3_OR:      alu_op = ALU_OR;
        F3_AND:     alu_op = ALU_AND;
        default:    alu_op = ALU_ADD;
      endcase
    end
  end

  assign alu_b = (opcode == OPC_OP) ? b : imm;

  always_comb begin
    case (alu_op)
      ALU_ADD: alu_res = a + alu_b;
      ALU_SUB: alu_res = a - alu_b;
      ALU_AND: alu_res = a & alu_b;
      ALU_OR:  alu_res = a | alu_b;
      ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(alu_b)};
      default: alu_res = '0;
    endcase
  end

  assign pc_plus4  = pc + XLEN'(4);
  assign br_target = pc + imm;
  assign taken     = (a == b) ^ (funct3 == F3_BNE);

  always_comb begin
    case (opcode)
      OPC_LOAD, OPC_STORE: exec_fault = (alu_res[1:0] != 2'b00);
      OPC_JAL:             exec_fault = (br_target[1:0] != 2'b00);
      OPC_BRANCH:          exec_fault = taken && (br_target[1:0] != 2'b00);
      default:             exec_fault = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc;
    retire   = 1'b0;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) state_nx = DECODE;
      end
      DECODE: state_nx = legal ? EXECUTE : HALT;
      EXECUTE: begin
        if (exec_fault) state_nx = HALT;
        else if (opcode == OPC_BRANCH) begin
          retire   = 1'b1;
          state_nx = FETCH;
        end else if (opcode == OPC_LOAD || opcode == OPC_STORE) state_nx = MEMORY;
        else state_nx = WRITEBACK;
      end
      MEMORY: begin
        mem_req  = 1'b1;
        mem_we   = is_store;
        mem_addr = alu_out;
        if (mem_ready) begin
          retire   = is_store;
          state_nx = is_store ? FETCH : WRITEBACK;
        end
      end
      WRITEBACK: begin
        retire   = 1'b1;
        state_nx = FETCH;
      end
      default: state_nx = HALT;
    endcase
    if (rst) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      retire  = 1'b0;
    end
  end

  assign halt      = (state == HALT) && !rst;
  assign mem_wdata = b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= state_nx;
      case (state)
        EXECUTE: if (!exec_fault) begin
          if (opcode == OPC_BRANCH) pc <= taken ? br_target : pc_plus4;
          else if (opcode == OPC_JAL) pc <= br_target;
        end
        MEMORY:    if (mem_ready && is_store) pc <= pc_plus4;
        WRITEBACK: if (opcode != OPC_JAL) pc <= pc_plus4;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      case (state)
        FETCH: if (mem_ready) ir <= mem_rdata;
        DECODE: begin
          a   <= rs1_data;
          b   <= rs2_data;
          imm <= imm_dec;
        end
        EXECUTE: alu_out <= (opcode == OPC_JAL) ? pc_plus4 : alu_res;
        MEMORY:  if (mem_ready) mdr <= mem_rdata;
        default: ;
      endcase
    end
  end

  assign rf_we    = (state == WRITEBACK) && !rst;
  assign rf_wdata = (opcode == OPC_LOAD) ? mdr : alu_out;

  rvmc_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rs1_addr (ir[15 +: AW]),
    .rs2_addr (ir[20 +: AW]),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .we       (rf_we),
    .rd_addr  (ir[7 +: AW]),
    .rd_data  (rf_wdata)
  );

endmodule

// File: tb/tb_risc_multicycle_core.sv
// Directed bench for risc_multicycle_core with a word-addressed memory model.
module tb_risc_multicycle_core;

  logic        clk;
  logic        rst;
  logic        mem_req, mem_we, mem_ready, retire, halt;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [256];

  int compared   = 0;
  int mismatched = 0;
  int now        = 0;

  // Monitor-owned observations, indexed by cycle number (cycle 1 = first fetch).
  int          cyc        = 0;
  int          retire_cnt = 0;
  int          stab_err   = 0;
  int          halt_err   = 0;
  int          range_err  = 0;
  bit          retire_at [512];
  logic [31:0] rd_at     [512];
  logic [31:0] st_addr_q [$];
  logic [31:0] st_data_q [$];
  logic        pend;
  logic [31:0] p_addr, p_wdata;
  logic        p_we;

  risc_multicycle_core #(
    .XLEN     (32),
    .RESET_PC (32'h100),
    .NREGS    (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .retire    (retire),
    .halt      (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb mem_rdata = mem[mem_addr[9:2]];

  always @(negedge clk) begin
    if (rst) begin
      cyc        = 0;
      retire_cnt = 0;
      pend       = 1'b0;
      for (int i = 0; i < 512; i++) begin
        retire_at[i] = 1'b0;
        rd_at[i]     = 'x;
      end
      st_addr_q.delete();
      st_data_q.delete();
    end else begin
      cyc++;
      if (cyc < 512) begin
        retire_at[cyc] = retire;
        if (mem_req && mem_ready && !mem_we) rd_at[cyc] = mem_addr;
      end
      if (retire) retire_cnt++;
      if (mem_req && mem_ready && mem_we) begin
        st_addr_q.push_back(mem_addr);
        st_data_q.push_back(mem_wdata);
      end
      if (pend && (!mem_req || mem_addr !== p_addr || mem_we !== p_we || (p_we && mem_wdata !== p_wdata)))
        stab_err++;
      pend    = mem_req && !mem_ready;
      p_addr  = mem_addr;
      p_we    = mem_we;
      p_wdata = mem_wdata;
      if (halt && (mem_req || retire)) halt_err++;
      if (mem_req && (mem_addr[31:10] != '0 || mem_addr[1:0] != 2'b00)) range_err++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      now++;
    end
  endtask

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    logic [31:0] v7, v2, v1, v3, vd;
    v7 = f7; v2 = rs2; v1 = rs1; v3 = f3; vd = rd;
    return {v7[6:0], v2[4:0], v1[4:0], v3[2:0], vd[4:0], 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int opc);
    logic [31:0] vi, v1, v3, vd, vo;
    vi = imm; v1 = rs1; v3 = f3; vd = rd; vo = opc;
    return {vi[11:0], v1[4:0], v3[2:0], vd[4:0], vo[6:0]};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [31:0] vi, v2, v1;
    vi = imm; v2 = rs2; v1 = rs1;
    return {vi[11:5], v2[4:0], v1[4:0], 3'b010, vi[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] vi, v2, v1, v3;
    vi = imm; v2 = rs2; v1 = rs1; v3 = f3;
    return {vi[12], vi[10:5], v2[4:0], v1[4:0], v3[2:0], vi[4:1], vi[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] vi, vd;
    vi = imm; vd = rd;
    return {vi[20], vi[10:1], vi[11], vi[19:12], vd[4:0], 7'h6F};
  endfunction

  task automatic put(input logic [31:0] addr, input logic [31:0] word);
    mem[addr[9:2]] = word;
  endtask

  logic [31:0] exp_st_addr [7] = '{32'h0, 32'h4, 32'h300, 32'h304, 32'h308, 32'h30C, 32'h310};
  logic [31:0] exp_st_data [7] = '{32'd12, 32'd12, 32'h128, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0};

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    put(32'h000, 32'd12);
    put(32'h100, enc_i(5, 0, 0, 1, 'h13));       // ADDI x1,x0,5
    put(32'h104, enc_i(7, 0, 0, 2, 'h13));       // ADDI x2,x0,7
    put(32'h108, enc_r(0, 2, 1, 0, 3));          // ADD  x3,x1,x2
    put(32'h10C, enc_s(0, 3, 0));                // SW   x3,0(x0)
    put(32'h110, enc_i(0, 0, 2, 4, 'h03));       // LW   x4,0(x0)
    put(32'h114, enc_s(4, 4, 0));                // SW   x4,4(x0)
    put(32'h118, enc_b(8, 1, 1, 0));             // BEQ  x1,x1,+8
    put(32'h11C, enc_i(1, 0, 0, 7, 'h13));       // skipped
    put(32'h120, enc_b(8, 1, 1, 1));             // BNE  x1,x1,+8
    put(32'h124, enc_j(-276, 5));                // JAL  x5,-0x114 -> 0x10
    put(32'h010, enc_s('h300, 5, 0));            // SW   x5,0x300(x0)
    put(32'h014, enc_i(9, 0, 0, 0, 'h13));       // ADDI x0,x0,9
    put(32'h018, enc_r(0, 0, 0, 0, 6));          // ADD  x6,x0,x0
    put(32'h01C, enc_s('h304, 6, 0));            // SW   x6
    put(32'h020, enc_i(1, 0, 0, 9, 'h13));       // ADDI x9,x0,1
    put(32'h024, enc_r('h20, 9, 0, 0, 8));       // SUB  x8,x0,x9
    put(32'h028, enc_s('h308, 8, 0));            // SW   x8
    put(32'h02C, enc_r(0, 9, 8, 2, 10));         // SLT  x10,x8,x9
    put(32'h030, enc_s('h30C, 10, 0));           // SW   x10
    put(32'h034, enc_r(0, 8, 9, 2, 11));         // SLT  x11,x9,x8
    put(32'h038, enc_s('h310, 11, 0));           // SW   x11
    put(32'h03C, 32'h0000_007F);                 // illegal opcode

    mem_ready = 1'b1;
    rst       = 1'b1;
    tick(3);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_we",  {31'b0, mem_we},  32'd0);
    check("rst_retire",  {31'b0, retire},  32'd0);
    check("rst_halt",    {31'b0, halt},    32'd0);

    rst = 1'b0;
    now = 1;
    #1;
    check("first_req",  {31'b0, mem_req}, 32'd1);
    check("first_addr", mem_addr, 32'h100);
    check("first_we",   {31'b0, mem_we}, 32'd0);

    tick(19);
    mem_ready = 1'b0;
    #1;
    check("lw_wait_req",  {31'b0, mem_req}, 32'd1);
    check("lw_wait_addr", mem_addr, 32'h0);
    tick(2);
    check("lw_wait_addr_late", mem_addr, 32'h0);
    check("lw_wait_we_late",   {31'b0, mem_we}, 32'd0);
    tick(1);
    mem_ready = 1'b1;

    tick(61);
    check("halt_before", {31'b0, halt}, 32'd0);
    tick(1);
    check("halt_rise", {31'b0, halt}, 32'd1);
    tick(10);
    check("halt_sticky", {31'b0, halt}, 32'd1);

    check("ret_c4",  {31'b0, retire_at[4]},  32'd1);
    check("ret_c8",  {31'b0, retire_at[8]},  32'd1);
    check("ret_c12", {31'b0, retire_at[12]}, 32'd1);
    check("ret_c16", {31'b0, retire_at[16]}, 32'd1);
    check("ret_c23", {31'b0, retire_at[23]}, 32'd0);
    check("ret_lw_c24", {31'b0, retire_at[24]}, 32'd1);
    check("ret_beq_c31", {31'b0, retire_at[31]}, 32'd1);
    check("ret_jal_c38", {31'b0, retire_at[38]}, 32'd1);
    check("lw_read_addr", rd_at[23], 32'h0);
    check("beq_next_fetch", rd_at[32], 32'h120);
    check("bne_next_fetch", rd_at[35], 32'h124);
    check("jal_next_fetch", rd_at[39], 32'h10);
    check("illegal_fetch",  rd_at[83], 32'h3C);
    check("retire_count_a", retire_cnt, 32'd20);
    check("store_count", st_addr_q.size(), 32'd7);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("st%0d_addr", i), (st_addr_q.size() > i) ? st_addr_q[i] : 'x, exp_st_addr[i]);
      check($sformatf("st%0d_data", i), (st_data_q.size() > i) ? st_data_q[i] : 'x, exp_st_data[i]);
    end

    rst = 1'b1;
    #1;
    check("rst_halt_cleared", {31'b0, halt},    32'd0);
    check("rst_halt_req",     {31'b0, mem_req}, 32'd0);
    check("rst_halt_retire",  {31'b0, retire},  32'd0);
    put(32'h100, enc_i(2, 0, 0, 1, 'h13));       // ADDI x1,x0,2
    put(32'h104, enc_i(0, 1, 2, 2, 'h03));       // LW   x2,0(x1) misaligned
    tick(2);
    rst       = 1'b0;
    now       = 1;
    mem_ready = 1'b0;
    tick(2);
    check("pending_fetch_req",  {31'b0, mem_req}, 32'd1);
    check("pending_fetch_addr", mem_addr, 32'h100);
    rst       = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("midrst_req", {31'b0, mem_req}, 32'd0);
    check("midrst_we",  {31'b0, mem_we},  32'd0);
    tick(1);
    rst = 1'b0;
    now = 1;
    #1;
    check("refetch_req",  {31'b0, mem_req}, 32'd1);
    check("refetch_addr", mem_addr, 32'h100);
    tick(6);
    check("mis_halt_before", {31'b0, halt}, 32'd0);
    tick(1);
    check("mis_halt_rise", {31'b0, halt}, 32'd1);
    tick(10);
    check("mis_halt_sticky", {31'b0, halt}, 32'd1);
    check("mis_fetch2", rd_at[5], 32'h104);
    check("mis_no_load", rd_at[7], 32'hxxxx_xxxx);
    check("retire_count_b", retire_cnt, 32'd1);
    check("ret_b_c4", {31'b0, retire_at[4]}, 32'd1);

    check("stable_errors", stab_err, 32'd0);
    check("halt_activity_errors", halt_err, 32'd0);
    check("addr_range_errors", range_err, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
